// File: rtl/logic_gate_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : logic_gate_pipe
//  Purpose  : Bitwise logic-op unit with a valid/ready FIFO output buffer and
//             a completed-handshake counter. Optional y_red via the macro
//             LOGIC_GATE_PIPE_REDUCE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module logic_gate_pipe #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int CW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [2:0]    op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  y,
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
   output logic          y_red,
`endif
   output logic [CW-1:0] count
);

   localparam int             c_AW      = $clog2(DEPTH);
   localparam logic [c_AW:0]  c_PTR_ONE = 1;
   localparam logic [CW-1:0]  c_CNT_ONE = 1;

   localparam logic [2:0] c_OP_AND  = 3'b000;
   localparam logic [2:0] c_OP_OR   = 3'b001;
   localparam logic [2:0] c_OP_NAND = 3'b010;
   localparam logic [2:0] c_OP_NOR  = 3'b011;
   localparam logic [2:0] c_OP_XOR  = 3'b100;
   localparam logic [2:0] c_OP_XNOR = 3'b101;
   localparam logic [2:0] c_OP_NOTA = 3'b110;

   logic [W-1:0]  r_mem [DEPTH];
   logic [c_AW:0] r_wr_ptr;
   logic [c_AW:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic [W-1:0]  w_result;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   always_comb begin
      w_result = a;
      case (op)
         c_OP_AND  : w_result = a & b;
         c_OP_OR   : w_result = a | b;
         c_OP_NAND : w_result = ~(a & b);
         c_OP_NOR  : w_result = ~(a | b);
         c_OP_XOR  : w_result = a ^ b;
         c_OP_XNOR : w_result = ~(a ^ b);
         c_OP_NOTA : w_result = ~a;
         default   : w_result = a;
      endcase
   end

   // Extra MSB on each pointer separates full from empty when the indices match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

   assign w_push  = in_valid && !w_full;
   assign w_pop   = out_ready && !w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_result;
            r_wr_ptr                  <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count  <= r_count + c_CNT_ONE;
         end
      end
   end

   // Storage is cleared on reset, so the head reads zero until the first push.
   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign y         = r_mem[r_rd_ptr[c_AW-1:0]];
   assign count     = r_count;

`ifdef LOGIC_GATE_PIPE_REDUCE_EN
   assign y_red = out_valid && (|y);
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_gate_pipe
//  Purpose  : Table-driven and scoreboard bench for logic_gate_pipe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logic_gate_pipe;

   localparam int W     = 8;
   localparam int DEPTH = 2;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [2:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  y;
   logic [CW-1:0] count;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
   logic          y_red;
`endif

   logic [W-1:0]  cur_exp;
   logic [W-1:0]  exp_q [$];
   logic [CW-1:0] exp_count;
   logic          seen_max;
   int            n_checks = 0;
   int            n_errors = 0;

   logic_gate_pipe #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
      .y_red     (y_red),
`endif
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   op;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic [2:0] mop);
      case (mop)
         3'd0: return ma & mb;
         3'd1: return ma | mb;
         3'd2: return ~(ma & mb);
         3'd3: return ~(ma | mb);
         3'd4: return ma ^ mb;
         3'd5: return ~(ma ^ mb);
         3'd6: return ~ma;
         default: return ma;
      endcase
   endfunction

   // Scoreboard: inputs are stable at the falling edge and decide the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_count = '0;
      end else begin
         automatic int  occ   = exp_q.size();
         automatic bit  do_po = out_ready && (occ != 0);
         automatic bit  do_pu = in_valid && (occ < DEPTH);
         check("in_ready", {63'd0, in_ready}, {63'd0, occ < DEPTH});
         check("out_valid", {63'd0, out_valid}, {63'd0, occ != 0});
         if (occ != 0) check("y_head", 64'(y), 64'(exp_q[0]));
         check("count", 64'(count), 64'(exp_count));
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
         check("y_red", {63'd0, y_red}, {63'd0, (occ != 0) && (|exp_q[0])});
`endif
         if (count == 4'hF) seen_max = 1'b1;
         if (do_po) begin
            void'(exp_q.pop_front());
            exp_count = exp_count + 1'b1;
         end
         if (do_pu) exp_q.push_back(cur_exp);
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top,
                       input logic [W-1:0] texp);
      int n = 0;
      a = ta; b = tb; op = top; cur_exp = texp; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [W-1:0] e1;
      logic [W-1:0] ta, tb;
      logic [2:0]   top;

      vecs[0]  = '{8'hF0, 8'hCC, 3'd0, 8'hC0};
      vecs[1]  = '{8'hF0, 8'hCC, 3'd1, 8'hFC};
      vecs[2]  = '{8'hF0, 8'hCC, 3'd2, 8'h3F};
      vecs[3]  = '{8'hF0, 8'hCC, 3'd3, 8'h03};
      vecs[4]  = '{8'hF0, 8'hCC, 3'd4, 8'h3C};
      vecs[5]  = '{8'hF0, 8'hCC, 3'd5, 8'hC3};
      vecs[6]  = '{8'hF0, 8'hCC, 3'd6, 8'h0F};
      vecs[7]  = '{8'hF0, 8'hCC, 3'd7, 8'hF0};
      vecs[8]  = '{8'hAA, 8'h55, 3'd1, 8'hFF};
      vecs[9]  = '{8'hAA, 8'h55, 3'd0, 8'h00};
      vecs[10] = '{8'h3C, 8'h0F, 3'd4, 8'h33};
      vecs[11] = '{8'h81, 8'hFF, 3'd5, 8'h81};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op = '0; cur_exp = '0; exp_count = '0; seen_max = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_y", 64'(y), 64'd0);
      check("rst_count", 64'(count), 64'd0);

      // Truth table, consumer always ready.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
         check("tt_latency_valid", {63'd0, out_valid}, 64'd1);
         check("tt_latency_y", 64'(y), 64'(vecs[i].exp));
      end
      @(posedge clk); #1;
      check("tt_count", 64'(count), 64'd8);
      for (int i = 8; i < 12; i++) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
      repeat (2) @(posedge clk); #1;

      // Backpressure: three NOR ops into a two-deep buffer.
      out_ready = 1'b0;
      e1 = model(8'h12, 8'h40, 3'd3);
      send(8'h12, 8'h40, 3'd3, e1);
      send(8'h00, 8'h0F, 3'd3, model(8'h00, 8'h0F, 3'd3));
      @(negedge clk);
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      fork
         send(8'h55, 8'h22, 3'd3, model(8'h55, 8'h22, 3'd3));
         begin
            repeat (3) begin
               @(negedge clk);
               check("bp_y_stable", 64'(y), 64'(e1));
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;
      check("bp_drained", {63'd0, out_valid}, 64'd0);

      // Full with simultaneous pop: pop happens, push waits one edge.
      out_ready = 1'b0;
      send(8'h01, 8'h02, 3'd1, 8'h03);
      send(8'h0F, 8'hF0, 3'd4, 8'hFF);
      a = 8'h77; b = 8'h00; op = 3'd7; cur_exp = 8'h77;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("fp_in_ready_full", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      check("fp_popped_y", 64'(y), 64'hFF);
      @(negedge clk);
      check("fp_in_ready_after", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk); #1;

      // Counter wrap with CW=4: 17 handshakes end at 1.
      pulse_reset();
      seen_max = 1'b0;
      for (int i = 0; i < 17; i++) begin
         ta = 8'($urandom); tb = 8'($urandom); top = 3'($urandom_range(0, 7));
         send(ta, tb, top, model(ta, tb, top));
      end
      repeat (3) @(posedge clk); #1;
      check("wrap_seen_15", {63'd0, seen_max}, 64'd1);
      check("wrap_final", 64'(count), 64'd1);

      // Reset mid-operation with two entries buffered.
      out_ready = 1'b0;
      send(8'hDE, 8'hAD, 3'd0, model(8'hDE, 8'hAD, 3'd0));
      send(8'hBE, 8'hEF, 3'd1, model(8'hBE, 8'hEF, 3'd1));
      a = 8'h11; b = 8'h22; op = 3'd1; cur_exp = 8'h33;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      check("mr_out_valid", {63'd0, out_valid}, 64'd0);
      check("mr_y", 64'(y), 64'd0);
      check("mr_count", 64'(count), 64'd0);
      check("mr_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (3) @(posedge clk); #1;
      check("mr_no_stale", {63'd0, out_valid}, 64'd0);

`ifdef LOGIC_GATE_PIPE_REDUCE_EN
      out_ready = 1'b1;
      send(8'hFF, 8'h00, 3'd3, 8'h00);
      check("red_zero", {63'd0, y_red}, 64'd0);
      send(8'h01, 8'hAB, 3'd7, 8'h01);
      check("red_one", {63'd0, y_red}, 64'd1);
      repeat (2) @(posedge clk); #1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 SHALL provide parameter W, default 8, operand/result width in bits (1..64).
REQ-002 SHALL provide parameter DEPTH, default 2, output buffer entries (power of two, 2..16).
REQ-003 SHALL provide parameter CW, default 16, completed-transaction counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operands/op presented.
REQ-007 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-008 SHALL have port a  input  W  operand A.
REQ-009 SHALL have port b  input  W  operand B.
REQ-010 SHALL have port op  input  3  operation select.
REQ-011 SHALL have port out_valid  output  1  head result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port y  output  W  head result.
REQ-014 SHALL have port count  output  CW  completed output handshakes.

Function
REQ-015 SHALL decode op bitwise: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a, 111 BUF a (b ignored for 110/111).
REQ-016 SHALL accept on clk edge where in_valid && in_ready; the op result is computed from a, b, op sampled that cycle and written to the buffer tail.
REQ-017 SHALL assert in_ready = !full; in_ready SHALL NOT depend combinationally on out_ready or in_valid.
REQ-018 SHALL drive out_valid = !empty and y = buffer head, registered only (no input-to-output combinational path).
REQ-019 SHALL have latency 1: result accepted at edge k visible on y with out_valid high after edge k, when buffer was empty.
REQ-020 SHALL pop the head on edge where out_valid && out_ready; y SHALL hold stable while out_valid && !out_ready.
REQ-021 SHALL, on simultaneous push and pop when neither full nor empty, perform both; occupancy unchanged.
REQ-022 SHALL, when full, refuse push even if a pop occurs that cycle (in_ready low); pop proceeds.
REQ-023 SHALL, when empty, ignore out_ready; no pop, no count change.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; full/empty distinguished by an extra pointer bit or occupancy counter (0..DEPTH).
REQ-025 SHALL increment count by 1 on each output handshake, wrapping 2^CW-1 -> 0.
REQ-026 SHALL preserve FIFO order: results emerge in acceptance order.

Reset
REQ-027 SHALL, with rst high at a clk edge, clear occupancy and pointers, count = 0, out_valid = 0, in_ready = 1, y = 0; in-flight and buffered results discarded.
REQ-028 SHALL ignore in_valid and out_ready during any cycle rst is high; rst mid-stream SHALL drop all stored entries.
REQ-029 SHALL become operational on the first edge after rst deasserts.

Configuration
REQ-030 SHALL, with macro LOGIC_GATE_PIPE_REDUCE_EN defined, add port y_red  output  1  = reduction-OR of y when out_valid, 0 otherwise (zero during/after reset).
REQ-031 SHALL, without LOGIC_GATE_PIPE_REDUCE_EN, omit y_red; all other behaviour identical.

Verification
REQ-032 SHALL cover truth table: W=8, a=8'hF0, b=8'hCC, out_ready=1, op 000..111 -> y = C0, FC, 3F, 03, 3C, C3, 0F, F0 in order, each one cycle after accept; count = 8.
REQ-033 SHALL cover backpressure: out_ready=0, push three NOR ops (DEPTH=2) -> in_ready low after second accept, third held; y stable at first result; release out_ready -> three results in order.
REQ-034 SHALL cover full with simultaneous pop: full, in_valid=1, out_ready=1 -> pop occurs, no push that edge, push on next edge.
REQ-035 SHALL cover counter wrap: CW=4, 17 handshakes -> count sequence reaches 15, then 0, ends at 1.
REQ-036 SHALL cover reset mid-operation: two entries buffered, rst high one edge -> out_valid=0, y=0, count=0, in_ready=1; stale data never emitted.
REQ-037 SHALL cover reduce option: macro defined, y=8'h00 (NOR of a=FF,b=00) -> y_red=0; y=8'h01 -> y_red=1; macro undefined builds without y_red.
